dcache_dm: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the execute/memory pipeline boundary and the backing data RAM.
- Serves word loads in the same cycle on a hit. On a miss it refills a whole line over a req/ack memory handshake.
- Every store is forwarded to memory with a byte mask. `stall` freezes the pipeline while memory traffic is outstanding.
- Returns raw 32-bit words; sign/zero extension and lane selection stay in the downstream load-format logic.

---
 rtl/dcache_dm_if.sv | 36 +++
 rtl/dcache_dm.sv | 158 +++++++++++++++
 tb/tb_dcache_dm.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_dm_if.sv
// dcache_dm_if: bundle of the load/store pipeline port and the backing-RAM
// req/ack port of the direct-mapped data cache.
//   Pipeline side : rd_en, wr_en, addr, wdata, be  -> cache
//                   rdata, stall                   <- cache
//   Memory side   : mem_req, mem_we, mem_addr, mem_wdata, mem_be <- cache
//                   mem_ack, mem_rdata                          -> cache
// modport slave  : the cache itself.
// modport master : the environment (pipeline + memory) around the cache.
interface dcache_dm_if #(
    parameter int WIDTH = 32
);
    logic             rd_en;
    logic             wr_en;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [3:0]       be;
    logic [WIDTH-1:0] rdata;
    logic             stall;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output rd_en, wr_en, addr, wdata, be, mem_ack, mem_rdata,
        input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  rd_en, wr_en, addr, wdata, be, mem_ack, mem_rdata,
        output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
// Loads hit in the same cycle; a miss refills the whole line word by word
// over the req/ack memory port. Every store goes to memory with its byte
// mask and updates the cached word only when the line is resident.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       pipeline request/response and memory req/ack signals
//   hit_count/miss_count (only with DCACHE_PERF_EN) saturating event counters
// Optional feature macro: DCACHE_PERF_EN.
module dcache_dm #(
    parameter int WIDTH      = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_dm_if.slave  bus
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int WO    = $clog2(LINE_WORDS);
    localparam int IW    = $clog2(LINES);
    localparam int CW    = (WO > 0) ? WO : 1;
    localparam int AW    = WO + IW;              // index + word offset = data array pointer
    localparam int TW    = WIDTH - 2 - AW;
    localparam int DEPTH = LINES * LINE_WORDS;

    localparam logic [AW-1:0]    WMASK     = AW'(LINE_WORDS - 1);
    localparam logic [CW-1:0]    LAST      = CW'(LINE_WORDS - 1);
    localparam logic [WIDTH-1:0] LINE_MASK = WIDTH'(LINE_WORDS * 4 - 1);
    localparam logic [WIDTH-1:0] BYTE_MASK = WIDTH'(3);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tags [LINES];
    logic [WIDTH-1:0] data [DEPTH];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag_in;
    logic [AW-1:0] dptr, fptr;
    logic          hit, fill_last, fill_we, store_we;

    assign idx       = bus.addr[2+WO +: IW];
    assign tag_in    = bus.addr[WIDTH-1 -: TW];
    assign dptr      = bus.addr[2 +: AW];
    assign fptr      = (dptr & ~WMASK) | AW'(cnt_q);
    assign hit       = valid_q[idx] && (tags[idx] == tag_in);
    assign fill_last = (cnt_q == LAST);

    always_comb begin
        state_d       = state_q;
        bus.stall     = 1'b0;
        bus.rdata     = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        fill_we       = 1'b0;
        store_we      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // a simultaneous load+store is handled as the store
                if (bus.wr_en) begin
                    bus.stall = 1'b1;
                    state_d   = S_WRITE;
                end else if (bus.rd_en) begin
                    if (hit) begin
                        bus.rdata = data[dptr];
                    end else begin
                        bus.stall = 1'b1;
                        state_d   = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = (bus.addr & ~LINE_MASK) | (WIDTH'(cnt_q) << 2);
                if (bus.mem_ack) begin
                    fill_we = 1'b1;
                    if (fill_last) state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.addr & ~BYTE_MASK;
                bus.mem_wdata = bus.wdata;
                bus.mem_be    = bus.be;
                // release the pipeline in the ack cycle so the next request
                // is presented while the FSM returns to IDLE
                bus.stall     = !bus.mem_ack;
                if (bus.mem_ack) begin
                    store_we = hit;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_we) begin
                cnt_q        <= fill_last ? '0 : cnt_q + CW'(1);
                // line is invalid while its words are being replaced, so an
                // interrupted refill never leaves a half-new line visible
                valid_q[idx] <= fill_last;
            end
        end
    end

    // tag/data storage needs no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data[fptr] <= bus.mem_rdata;
            if (fill_last) tags[idx] <= tag_in;
        end
        if (store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be[b]) data[dptr][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

`ifdef DCACHE_PERF_EN
    // replay_q marks the IDLE cycle right after a refill, where the held
    // load hits but was already counted as a miss
    logic replay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            replay_q   <= 1'b0;
        end else begin
            replay_q <= fill_we && fill_last;
            if (state_q == S_IDLE && bus.rd_en && !bus.wr_en && hit && !replay_q
                && hit_count != '1)
                hit_count <= hit_count + 32'd1;
            if (state_q == S_IDLE && state_d == S_REFILL && miss_count != '1)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: self-checking bench for dcache_dm. A transaction-level model
// (which line tag is resident per index, plus a word-addressed RAM image)
// predicts stall/rdata/memory requests every cycle; directed scenarios pin
// latencies and data with literal values, then randomized traffic follows.
`timescale 1ns/1ps
module tb_dcache_dm;
    localparam int WIDTH      = 32;
    localparam int LINES      = 16;
    localparam int LINE_WORDS = 4;
    localparam int LB         = LINE_WORDS * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_dm_if #(.WIDTH(WIDTH)) bus ();
`ifdef DCACHE_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_dm #(.WIDTH(WIDTH), .LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DCACHE_PERF_EN
        , .hit_count (hit_count)
        , .miss_count(miss_count)
`endif
    );

    int checks = 0;
    int fails  = 0;
    int lat_max = 0;
    logic [31:0] ram [int];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ram_rd(logic [31:0] a);
        int k = int'(a >> 2);
        if (ram.exists(k)) return ram[k];
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void ram_wr(logic [31:0] a, logic [31:0] d, logic [3:0] b);
        logic [31:0] w = ram_rd(a);
        for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = d[8*i +: 8];
        ram[int'(a >> 2)] = w;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } txn_t;

    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    txn_t        expq[$];
    bit          busy = 0;
    logic [31:0] fill_a;

    function automatic int m_idx(logic [31:0] a);
        return int'((a / LB) % LINES);
    endfunction

    function automatic bit m_hit(logic [31:0] a);
        return mvalid[m_idx(a)] && (mtag[m_idx(a)] == a / (LB * LINES));
    endfunction

    always @(negedge clk) begin
        txn_t t;
        if (!rst_n) begin
            chk("rst_ctl", 32'({bus.stall, bus.mem_req, bus.mem_we, bus.mem_be}), 32'd0);
            chk("rst_rdata", bus.rdata, 32'd0);
            chk("rst_mem_addr", bus.mem_addr, 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
            for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
            expq.delete();
            busy = 0;
        end else if (busy && expq.size() > 0) begin
            t = expq[0];
            chk("mem_req", 32'(bus.mem_req), 32'd1);
            chk("mem_we", 32'(bus.mem_we), 32'(t.we));
            chk("mem_addr", bus.mem_addr, t.a);
            chk("busy_rdata", bus.rdata, 32'd0);
            if (t.we) begin
                chk("mem_wdata", bus.mem_wdata, t.d);
                chk("mem_be", 32'(bus.mem_be), 32'(t.b));
            end
            chk("busy_stall", 32'(bus.stall), (t.we && bus.mem_ack) ? 32'd0 : 32'd1);
            if (bus.mem_ack) begin
                if (t.we) ram_wr(t.a, t.d, t.b);
                void'(expq.pop_front());
                if (expq.size() == 0) begin
                    busy = 0;
                    if (!t.we) begin
                        mvalid[m_idx(fill_a)] = 1'b1;
                        mtag[m_idx(fill_a)]   = fill_a / (LB * LINES);
                    end
                end
            end
        end else begin
            chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
            if (bus.wr_en) begin
                chk("st_stall", 32'(bus.stall), 32'd1);
                expq.push_back('{we: 1'b1, a: bus.addr & ~32'd3, d: bus.wdata, b: bus.be});
                busy = 1;
            end else if (bus.rd_en) begin
                if (m_hit(bus.addr)) begin
                    chk("hit_stall", 32'(bus.stall), 32'd0);
                    chk("hit_rdata", bus.rdata, ram_rd(bus.addr));
                end else begin
                    chk("miss_stall", 32'(bus.stall), 32'd1);
                    chk("miss_rdata", bus.rdata, 32'd0);
                    fill_a = bus.addr;
                    for (int k = 0; k < LINE_WORDS; k++)
                        expq.push_back('{we: 1'b0, a: 32'((bus.addr / LB) * LB + k * 4),
                                         d: 32'd0, b: 4'd0});
                    busy = 1;
                end
            end else begin
                chk("nop_stall", 32'(bus.stall), 32'd0);
                chk("nop_rdata", bus.rdata, 32'd0);
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        int wl;
        wl = -1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && bus.mem_req) begin
                if (wl < 0) wl = int'($urandom_range(lat_max, 0));
                if (wl == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_we ? $urandom : ram_rd(bus.mem_addr);
                    wl = -1;
                end else begin
                    bus.mem_ack = 1'b0;
                    wl--;
                end
            end else begin
                // stray acks with no request outstanding must be ignored
                bus.mem_ack   = ($urandom_range(0, 3) == 0);
                bus.mem_rdata = $urandom;
                wl = -1;
            end
        end
    end

    // ---------------- driver ----------------
    logic [31:0] seen[$];

    task automatic op(input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b,
                      output logic [31:0] rd, output int nst);
        bit done = 0;
        @(posedge clk);
        #1;
        bus.rd_en = r; bus.wr_en = w; bus.addr = a; bus.wdata = wd; bus.be = b;
        seen.delete();
        nst = 0;
        rd  = '0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_ack) seen.push_back(bus.mem_addr);
            if (bus.stall) nst++;
            else begin
                rd   = bus.rdata;
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL op_timeout addr=%h stalled=%0d required=release", a, nst);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a;
        int nst, kind, acks;
        bus.rd_en = 0; bus.wr_en = 0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
        for (int k = 0; k < 4; k++) ram[16 + k] = 32'hA0 + 32'(k);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        lat_max = 0;

        // cold load
        op(0, 1, 32'h40, 0, 0, rd, nst);
        chk("cold_stall_cycles", 32'(nst), 32'd5);
        chk("cold_nreq", 32'(seen.size()), 32'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            chk("cold_addr", seen[k], 32'h40 + 32'(4 * k));
        chk("cold_rdata", rd, 32'hA0);

        // hit after refill
        op(0, 1, 32'h48, 0, 0, rd, nst);
        chk("hit_cycles", 32'(nst), 32'd0);
        chk("hit_nreq", 32'(seen.size()), 32'd0);
        chk("hit_word", rd, 32'hA2);

        // store hit, partial byte enable
        op(1, 0, 32'h44, 32'h0000_BB00, 4'b0010, rd, nst);
        chk("sthit_nreq", 32'(seen.size()), 32'd1);
        chk("sthit_cycles", 32'(nst), 32'd1);
        if (seen.size() > 0) chk("sthit_addr", seen[0], 32'h44);
        op(0, 1, 32'h44, 0, 0, rd, nst);
        chk("sthit_reload", rd, 32'h0000_BBA1);
        chk("sthit_reload_cycles", 32'(nst), 32'd0);

        // store miss, no allocate
        op(1, 0, 32'h400, 32'h1234_5678, 4'hF, rd, nst);
        chk("stmiss_nreq", 32'(seen.size()), 32'd1);
        op(0, 1, 32'h400, 0, 0, rd, nst);
        chk("stmiss_load_cycles", 32'(nst), 32'd5);
        chk("stmiss_load_nreq", 32'(seen.size()), 32'd4);
        chk("stmiss_load_data", rd, 32'h1234_5678);

        // conflict eviction on index 4
        op(0, 1, 32'h40, 0, 0, rd, nst);
        chk("evict_pre_cycles", 32'(nst), 32'd0);
        op(0, 1, 32'h140, 0, 0, rd, nst);
        chk("evict_cycles", 32'(nst), 32'd5);
        op(0, 1, 32'h40, 0, 0, rd, nst);
        chk("evict_reload_cycles", 32'(nst), 32'd5);
        chk("evict_reload_data", rd, 32'hA0);

        // reset in the middle of a refill
        @(posedge clk);
        #1;
        bus.rd_en = 1; bus.wr_en = 0; bus.addr = 32'h80;
        acks = 0;
        for (int c = 0; c < 50 && acks < 2; c++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_ack) acks++;
        end
        chk("midrst_acks", 32'(acks), 32'd2);
        @(posedge clk);
        #3;
        rst_n = 0;
        bus.rd_en = 0;
        #1;
        chk("midrst_req_drop", 32'(bus.mem_req), 32'd0);
        chk("midrst_stall_drop", 32'(bus.stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        op(0, 1, 32'h80, 0, 0, rd, nst);
        chk("midrst_refill_cycles", 32'(nst), 32'd5);
        chk("midrst_refill_nreq", 32'(seen.size()), 32'd4);
        if (seen.size() > 0) chk("midrst_refill_first", seen[0], 32'h80);
        chk("midrst_refill_data", rd, ram_rd(32'h80));

        // randomized traffic; the per-cycle model does the checking
        for (int n = 0; n < 400; n++) begin
            kind    = int'($urandom_range(0, 19));
            lat_max = int'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 2) * 256 + $urandom_range(0, 15) * 16
                    + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
            if (kind < 10)      op(0, 1, a, 0, 0, rd, nst);
            else if (kind < 17) op(1, 0, a, $urandom, 4'($urandom_range(0, 15)), rd, nst);
            else if (kind < 19) op(1, 1, a, $urandom, 4'($urandom_range(0, 15)), rd, nst);
            else                op(0, 0, a, 0, 0, rd, nst);
        end

        op(0, 0, 0, 0, 0, rd, nst);
        @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
